// File: rtl/sequenciador_notas_if.sv
// -----------------------------------------------------------------------------
// sequenciador_notas_if
//   Bundles the signals between the note playback sequencer and its
//   environment (round controller, note ROM, buzzer/Arduino output).
//
//   master : environment side. Drives the start/abort commands, the sequence
//            length and the ROM read data. Observes the sequencer outputs.
//   slave  : the sequencer itself.
//
//   Signals
//     iniciar      start playback (only honoured while idle)
//     abortar      stop playback immediately
//     comprimento  index of the last note to play (0 = one note)
//     dado_memoria note read from the synchronous ROM, one cycle after endereco
//     endereco     ROM read address
//     nota         note code driven to the buzzer/Arduino (0 = rest)
//     nota_valida  high while a non-rest note is sounding
//     fim_nota     one-cycle pulse after each note's silent gap
//     pronto       one-cycle pulse after the last note completes
//     ocupado      high whenever the sequencer is not idle
//     db_estado    current state encoding, for debug
// -----------------------------------------------------------------------------
interface sequenciador_notas_if #(
  parameter int ADDR_W = 4,
  parameter int NOTE_W = 4
);

  logic              iniciar;
  logic              abortar;
  logic [ADDR_W-1:0] comprimento;
  logic [NOTE_W-1:0] dado_memoria;

  logic [ADDR_W-1:0] endereco;
  logic [NOTE_W-1:0] nota;
  logic              nota_valida;
  logic              fim_nota;
  logic              pronto;
  logic              ocupado;
  logic [2:0]        db_estado;

  modport master (
    output iniciar,
    output abortar,
    output comprimento,
    output dado_memoria,
    input  endereco,
    input  nota,
    input  nota_valida,
    input  fim_nota,
    input  pronto,
    input  ocupado,
    input  db_estado
  );

  modport slave (
    input  iniciar,
    input  abortar,
    input  comprimento,
    input  dado_memoria,
    output endereco,
    output nota,
    output nota_valida,
    output fim_nota,
    output pronto,
    output ocupado,
    output db_estado
  );

endinterface

// File: rtl/sequenciador_notas.sv
// -----------------------------------------------------------------------------
// sequenciador_notas
//   Playback sequencer for the "show sequence" phase of a round. On iniciar
//   it walks ROM addresses 0..comprimento; each note is sounded for T_NOTA
//   cycles, followed by T_PAUSA cycles of silence. fim_nota pulses after
//   every note and pronto after the last one, so the round controller can
//   pace its display from these pulses instead of running its own timer.
//
//   Per note: LE (address to ROM) -> CAPTURA (latch ROM data) -> TOCA
//   (T_NOTA cycles) -> PAUSA (T_PAUSA cycles) -> PROXIMO (fim_nota), i.e.
//   T_NOTA+T_PAUSA+3 cycles per note. After the last note, FIM (pronto).
//
//   Ports
//     clock  system clock, rising edge
//     reset  synchronous, active-high reset; priority over all inputs
//     bus    sequenciador_notas_if.slave (commands, ROM data, outputs)
//
//   All outputs are registered (Moore); none depends combinationally on an
//   input.
// -----------------------------------------------------------------------------
module sequenciador_notas #(
  parameter int ADDR_W  = 4,
  parameter int NOTE_W  = 4,
  parameter int T_NOTA  = 25000000,
  parameter int T_PAUSA = 5000000,
  parameter int TIMER_W = 26
) (
  input  logic                  clock,
  input  logic                  reset,
  sequenciador_notas_if.slave   bus
);

  // Encoding is visible on db_estado, so values are pinned explicitly.
  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    LE      = 3'd1,
    CAPTURA = 3'd2,
    TOCA    = 3'd3,
    PAUSA   = 3'd4,
    PROXIMO = 3'd5,
    FIM     = 3'd6
  } estado_t;

  // Terminal counts for the two timed states.
  localparam logic [TIMER_W-1:0] FIM_TOCA  = TIMER_W'(T_NOTA - 1);
  localparam logic [TIMER_W-1:0] FIM_PAUSA = TIMER_W'(T_PAUSA - 1);

  estado_t            estado;
  logic [ADDR_W-1:0]  endereco;
  logic [ADDR_W-1:0]  limite;    // comprimento latched at start
  logic [TIMER_W-1:0] timer;
  logic [NOTE_W-1:0]  nota;
  logic               nota_valida;
  logic               fim_nota;
  logic               pronto;
  logic               ocupado;

  // ---------------------------------------------------------------------------
  // Single-process FSM. Outputs are registered alongside the state, so each
  // output is set on the transition INTO the state where it must be seen.
  // ---------------------------------------------------------------------------
  // NOTE: every register here uses non-blocking assignment so all of them
  // update together from the same pre-edge values; blocking assignment would
  // let later statements see half-updated state.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado      <= OCIOSO;
      endereco    <= '0;
      limite      <= '0;
      timer       <= '0;
      nota        <= '0;
      nota_valida <= 1'b0;
      fim_nota    <= 1'b0;
      pronto      <= 1'b0;
      ocupado     <= 1'b0;
    end else begin
      // Pulse outputs default low; only the transitions that own them raise
      // them for exactly one cycle.
      fim_nota <= 1'b0;
      pronto   <= 1'b0;

      if (estado != OCIOSO && bus.abortar) begin
        // Abort wins over every other transition, including PROXIMO->FIM.
        // endereco is deliberately left where it was.
        estado      <= OCIOSO;
        nota        <= '0;
        timer       <= '0;
        nota_valida <= 1'b0;
        ocupado     <= 1'b0;
      end else begin
        case (estado)
          OCIOSO: begin
            // iniciar together with abortar is treated as no start.
            if (bus.iniciar && !bus.abortar) begin
              estado   <= LE;
              endereco <= '0;
              limite   <= bus.comprimento;
              timer    <= '0;
              ocupado  <= 1'b1;
            end
          end

          LE: begin
            // endereco is on the ROM address bus this cycle; data arrives
            // on dado_memoria in the next one.
            estado <= CAPTURA;
          end

          CAPTURA: begin
            nota        <= bus.dado_memoria;
            nota_valida <= (bus.dado_memoria != '0);
            timer       <= '0;
            estado      <= TOCA;
          end

          TOCA: begin
            if (timer == FIM_TOCA) begin
              timer       <= '0;
              nota_valida <= 1'b0;
              estado      <= PAUSA;
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end

          PAUSA: begin
            // nota keeps its value through the gap; only nota_valida drops.
            if (timer == FIM_PAUSA) begin
              timer    <= '0;
              fim_nota <= 1'b1;
              estado   <= PROXIMO;
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end

          PROXIMO: begin
            // End is detected by equality before endereco can wrap, since
            // limite never exceeds the largest address.
            if (endereco == limite) begin
              pronto <= 1'b1;
              estado <= FIM;
            end else begin
              endereco <= endereco + ADDR_W'(1);
              estado   <= LE;
            end
          end

          FIM: begin
            nota    <= '0;
            ocupado <= 1'b0;
            estado  <= OCIOSO;
          end

          default: begin
            // Unused encoding 7: recover to idle with quiet outputs.
            nota        <= '0;
            nota_valida <= 1'b0;
            ocupado     <= 1'b0;
            timer       <= '0;
            estado      <= OCIOSO;
          end
        endcase
      end
    end
  end

  assign bus.endereco    = endereco;
  assign bus.nota        = nota;
  assign bus.nota_valida = nota_valida;
  assign bus.fim_nota    = fim_nota;
  assign bus.pronto      = pronto;
  assign bus.ocupado     = ocupado;
  assign bus.db_estado   = estado;

endmodule

// File: tb/tb_sequenciador_notas.sv
// -----------------------------------------------------------------------------
// tb_sequenciador_notas
//   Self-checking bench for sequenciador_notas with T_NOTA=4, T_PAUSA=2
//   (9 cycles per note). A reference timeline computes, for any cycle r
//   after the start cycle, what every output must be, using only the
//   per-note arithmetic (note index = (r-1)/P, phase = (r-1)%P).
// -----------------------------------------------------------------------------
module tb_sequenciador_notas;

  localparam int ADDR_W  = 4;
  localparam int NOTE_W  = 4;
  localparam int T_NOTA  = 4;
  localparam int T_PAUSA = 2;
  localparam int TIMER_W = 3;
  localparam int P       = T_NOTA + T_PAUSA + 3;

  typedef struct packed {
    logic [ADDR_W-1:0] endereco;
    logic [NOTE_W-1:0] nota;
    logic              nota_valida;
    logic              fim_nota;
    logic              pronto;
    logic              ocupado;
    logic [2:0]        estado;
  } out_t;

  typedef struct {
    int comp;
    int rom0;
    int abort_r;     // cycle at which abortar is high, -1 = never
    int reini_r;     // cycle of a spurious iniciar while busy, -1 = never
    int comp_novo;   // comprimento applied at reini_r
    int exp_fims;
    int exp_pronto_r;
  } vec_t;

  logic clock;
  logic reset;
  logic [NOTE_W-1:0] rom [16];
  logic [ADDR_W-1:0] last_end;

  int n_checks;
  int n_errors;

  sequenciador_notas_if #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W)) bus ();

  sequenciador_notas #(
    .ADDR_W (ADDR_W),
    .NOTE_W (NOTE_W),
    .T_NOTA (T_NOTA),
    .T_PAUSA(T_PAUSA),
    .TIMER_W(TIMER_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous ROM: one cycle of read latency.
  always @(posedge clock) bus.dado_memoria <= rom[bus.endereco];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int r, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s r=%0d got=%h expected=%h", name, r, got, exp);
    end
  endtask

  function automatic out_t observe();
    out_t o;
    o.endereco    = bus.endereco;
    o.nota        = bus.nota;
    o.nota_valida = bus.nota_valida;
    o.fim_nota    = bus.fim_nota;
    o.pronto      = bus.pronto;
    o.ocupado     = bus.ocupado;
    o.estado      = bus.db_estado;
    return o;
  endfunction

  // Expected outputs r cycles after the start cycle, without abort.
  function automatic out_t model(int r, int len, logic [ADDR_W-1:0] e0);
    out_t o;
    int   fim_r;
    int   n;
    int   p;
    o     = '0;
    fim_r = 1 + (len + 1) * P;
    if (r < 1) begin
      o.endereco = e0;
    end else if (r < fim_r) begin
      n = (r - 1) / P;
      p = (r - 1) % P;
      o.endereco = ADDR_W'(n);
      o.ocupado  = 1'b1;
      if (p < 2) begin
        o.estado = (p == 0) ? 3'd1 : 3'd2;
        o.nota   = (n == 0) ? '0 : rom[n-1];
      end else if (p < 2 + T_NOTA) begin
        o.estado      = 3'd3;
        o.nota        = rom[n];
        o.nota_valida = (rom[n] != '0);
      end else if (p < P - 1) begin
        o.estado = 3'd4;
        o.nota   = rom[n];
      end else begin
        o.estado   = 3'd5;
        o.nota     = rom[n];
        o.fim_nota = 1'b1;
      end
    end else if (r == fim_r) begin
      o.estado   = 3'd6;
      o.endereco = ADDR_W'(len);
      o.nota     = rom[len];
      o.pronto   = 1'b1;
      o.ocupado  = 1'b1;
    end else begin
      o.endereco = ADDR_W'(len);
    end
    return o;
  endfunction

  // One playback from start cycle r=0, comparing every output every cycle.
  task automatic run(input int len, input int abort_r, input int reini_r,
                     input int comp_novo, output int fims, output int pronto_r);
    logic [ADDR_W-1:0] e0;
    out_t exp;
    int   fim_r;
    int   stop;
    e0       = last_end;
    fims     = 0;
    pronto_r = -1;
    fim_r    = 1 + (len + 1) * P;
    stop     = ((abort_r >= 1) ? abort_r : fim_r) + 3;
    bus.comprimento = ADDR_W'(len);
    for (int r = 0; r <= stop; r++) begin
      bus.iniciar = (r == 0) || (r == reini_r);
      bus.abortar = (r == abort_r);
      if (r == reini_r) bus.comprimento = ADDR_W'(comp_novo);
      exp = model(r, len, e0);
      if (abort_r >= 1 && r > abort_r) begin
        exp          = '0;
        exp.endereco = model(abort_r, len, e0).endereco;
      end
      check("ciclo", r, 32'(observe()), 32'(exp));
      if (bus.fim_nota === 1'b1) fims++;
      if (bus.pronto === 1'b1) pronto_r = r;
      last_end = exp.endereco;
      tick();
    end
    bus.iniciar = 1'b0;
    bus.abortar = 1'b0;
  endtask

  initial begin
    vec_t vecs [6];
    int   fims;
    int   pronto_r;
    int   len;
    int   fim_r;
    int   abort_r;
    int   reini_r;
    int   lim;

    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 16; i++) rom[i] = NOTE_W'(i);
    bus.iniciar      = 1'b0;
    bus.abortar      = 1'b0;
    bus.comprimento  = '0;
    reset            = 1'b1;
    bus.iniciar      = 1'b1;   // reset must win over a start request
    repeat (3) tick();
    check("reset", 0, 32'(observe()), 32'(out_t'('0)));
    bus.iniciar = 1'b0;
    reset       = 1'b0;
    last_end    = '0;
    tick();

    // -------- table-driven scenarios (relative cycles from the start) -------
    vecs[0] = '{comp: 2,  rom0: 3, abort_r: -1, reini_r: -1, comp_novo: 2, exp_fims: 3,  exp_pronto_r: 28};
    vecs[1] = '{comp: 0,  rom0: 7, abort_r: -1, reini_r: -1, comp_novo: 0, exp_fims: 1,  exp_pronto_r: 10};
    vecs[2] = '{comp: 2,  rom0: 3, abort_r: 13, reini_r: -1, comp_novo: 2, exp_fims: 1,  exp_pronto_r: -1};
    vecs[3] = '{comp: 2,  rom0: 3, abort_r: -1, reini_r: -1, comp_novo: 2, exp_fims: 3,  exp_pronto_r: 28};
    vecs[4] = '{comp: 2,  rom0: 3, abort_r: -1, reini_r: 5,  comp_novo: 5, exp_fims: 3,  exp_pronto_r: 28};
    vecs[5] = '{comp: 15, rom0: 3, abort_r: -1, reini_r: -1, comp_novo: 15, exp_fims: 16, exp_pronto_r: 145};

    for (int i = 0; i < 6; i++) begin
      rom[0] = NOTE_W'(vecs[i].rom0);
      rom[1] = '0;
      rom[2] = 4'd5;
      run(vecs[i].comp, vecs[i].abort_r, vecs[i].reini_r, vecs[i].comp_novo,
          fims, pronto_r);
      check("fim_nota_count", i, 32'(fims), 32'(vecs[i].exp_fims));
      check("pronto_cycle", i, 32'(pronto_r), 32'(vecs[i].exp_pronto_r));
    end

    // -------- reset during PAUSA of note 1, then iniciar+abortar idle -------
    begin
      logic [ADDR_W-1:0] e0;
      e0 = last_end;
      bus.comprimento = 4'd2;
      for (int r = 0; r <= 16; r++) begin
        bus.iniciar = (r == 0);
        check("pre_reset", r, 32'(observe()), 32'(model(r, 2, e0)));
        if (r == 16) reset = 1'b1;
        tick();
      end
      check("reset_in_pausa", 17, 32'(observe()), 32'(out_t'('0)));
      reset       = 1'b0;
      last_end    = '0;
      bus.iniciar = 1'b1;
      bus.abortar = 1'b1;
      tick();
      bus.iniciar = 1'b0;
      bus.abortar = 1'b0;
      for (int r = 0; r < 3; r++) begin
        check("iniciar_com_abortar", r, 32'(observe()), 32'(out_t'('0)));
        tick();
      end
    end

    // -------- randomized playbacks against the reference timeline -----------
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 16; i++)
        rom[i] = ($urandom_range(0, 3) == 0) ? '0 : NOTE_W'($urandom_range(1, 15));
      len   = $urandom_range(0, 6);
      fim_r = 1 + (len + 1) * P;
      abort_r = ($urandom_range(0, 1) == 1) ? $urandom_range(1, fim_r) : -1;
      lim     = (abort_r >= 1) ? abort_r : fim_r;
      reini_r = ($urandom_range(0, 1) == 1) ? $urandom_range(1, lim) : -1;
      run(len, abort_r, reini_r, $urandom_range(0, 15), fims, pronto_r);
      if (abort_r < 0) begin
        check("rnd_fim_nota_count", t, 32'(fims), 32'(len + 1));
        check("rnd_pronto_cycle", t, 32'(pronto_r), 32'(fim_r));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
